// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle
// valid / framing-error strobes. The received byte is held until the next good frame.
`timescale 1ns / 1ps

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitHigh = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_meta_q, rx_s_q;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        // A held break must release the line before another frame can start.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: scoreboard of expected
// receive events plus a frame table and hand-written corner-case sequences.
`timescale 1ns / 1ps

module tb_uart_rx;

  localparam int unsigned Cpb = 16;
  localparam int BitNs = Cpb * 10;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  typedef struct {
    logic       is_valid;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    int         period_ns;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[4];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] exp_hold = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int period_ns, input logic stop);
    rx = 1'b0;
    #(period_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(period_ns);
    end
    rx = stop;
    #(period_ns);
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic is_valid, input logic [7:0] d);
    exp_t e;
    e.is_valid = is_valid;
    e.data     = d;
    sb.push_back(e);
  endtask

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(k < budget, "wait_quiet_timeout", k, budget);
    repeat (2 * Cpb) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rx_valid || frame_err)) begin
        check(!(rx_valid && frame_err), "valid_err_exclusive", {rx_valid, frame_err}, 0);
        check(sb.size() != 0, "event_expected", sb.size(), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(rx_valid == e.is_valid, "event_kind_valid", rx_valid, e.is_valid);
          if (e.is_valid) begin
            check(rx_data == e.data, "rx_data", rx_data, e.data);
            exp_hold = e.data;
          end
        end
        if (rx_valid) begin
          check(busy == 1'b0, "busy_low_at_valid", busy, 0);
          n_valid++;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end else begin
          check(rx_data == exp_hold, "rx_data_held_on_err", rx_data, exp_hold);
          n_err++;
        end
      end
    end
  end

  initial begin
    int fall_cyc;
    int nv;
    int ne;
    vecs[0] = '{8'h96, 166, 1'b1, 1'b1, 1'b0, 8'h96};
    vecs[1] = '{8'h96, 154, 1'b1, 1'b1, 1'b0, 8'h96};
    vecs[2] = '{8'hC3, BitNs, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{8'h81, BitNs, 1'b1, 1'b1, 1'b0, 8'h81};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
    check(rx_valid == 1'b0, "reset_rx_valid", rx_valid, 0);
    check(frame_err == 1'b0, "reset_frame_err", frame_err, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Nominal 0xA5 with latency from the falling edge.
    fall_cyc = cyc;
    nv = n_valid;
    ne = n_err;
    push_exp(1'b1, 8'hA5);
    send_frame(8'hA5, BitNs, 1'b1);
    wait_quiet(400);
    check(n_valid - nv == 1, "a5_valid_count", n_valid - nv, 1);
    check(n_err == ne, "a5_no_err", n_err - ne, 0);
    check(last_valid_cyc - fall_cyc >= 153 && last_valid_cyc - fall_cyc <= 155,
          "a5_latency", last_valid_cyc - fall_cyc, 154);

    // Table: baud mismatch and framing error.
    for (int i = 0; i < 4; i++) begin
      nv = n_valid;
      ne = n_err;
      if (vecs[i].exp_valid || vecs[i].exp_err) push_exp(vecs[i].exp_valid, vecs[i].exp_data);
      send_frame(vecs[i].din, vecs[i].period_ns, vecs[i].stop_bit);
      wait_quiet(400);
      check(n_valid - nv == int'(vecs[i].exp_valid), "vec_valid_count", n_valid - nv,
            int'(vecs[i].exp_valid));
      check(n_err - ne == int'(vecs[i].exp_err), "vec_err_count", n_err - ne,
            int'(vecs[i].exp_err));
    end

    // Glitch shorter than half a bit.
    nv = n_valid;
    ne = n_err;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check(busy == 1'b1, "glitch_busy_high", busy, 1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check(busy == 1'b0, "glitch_busy_low", busy, 0);
    check(n_valid == nv && n_err == ne, "glitch_no_event", n_valid + n_err - nv - ne, 0);
    check(rx_data == exp_hold, "glitch_rx_data_kept", rx_data, exp_hold);

    // Break: line low for 20 bit times.
    nv = n_valid;
    ne = n_err;
    push_exp(1'b0, 8'h00);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    check(busy == 1'b1, "break_busy_mid", busy, 1);
    repeat (20 * Cpb - 200) @(negedge clk);
    check(busy == 1'b1, "break_busy_end", busy, 1);
    check(n_err - ne == 1, "break_one_err", n_err - ne, 1);
    check(n_valid == nv, "break_no_valid", n_valid - nv, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check(busy == 1'b0, "break_busy_release", busy, 0);
    repeat (2 * Cpb) @(negedge clk);
    push_exp(1'b1, 8'h3C);
    send_frame(8'h3C, BitNs, 1'b1);
    wait_quiet(400);

    // Back-to-back frames with no idle gap.
    nv = n_valid;
    push_exp(1'b1, 8'h00);
    push_exp(1'b1, 8'hFF);
    send_frame(8'h00, BitNs, 1'b1);
    send_frame(8'hFF, BitNs, 1'b1);
    wait_quiet(400);
    check(n_valid - nv == 2, "b2b_valid_count", n_valid - nv, 2);
    check(last_valid_cyc - prev_valid_cyc >= 159 && last_valid_cyc - prev_valid_cyc <= 161,
          "b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);

    // Reset during data bit 3 of a frame; partial byte discarded.
    nv = n_valid;
    rx = 1'b0;
    #(BitNs);
    rx = 1'b1;
    #(3 * BitNs + BitNs / 4 + 3);
    reset = 1'b1;
    #1;
    exp_hold = 8'h00;
    check(rx_data == 8'h00, "midreset_rx_data", rx_data, 0);
    check(rx_valid == 1'b0, "midreset_rx_valid", rx_valid, 0);
    check(busy == 1'b0, "midreset_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * Cpb) @(negedge clk);
    check(n_valid == nv, "midreset_no_valid", n_valid - nv, 0);
    push_exp(1'b1, 8'h5A);
    send_frame(8'h5A, BitNs, 1'b1);
    wait_quiet(400);
    check(n_valid - nv == 1, "post_reset_valid_count", n_valid - nv, 1);

    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver. It is the receive-side counterpart of the 4-bit LED counter / UART transmitter path. It deserialises an asynchronous serial line into bytes, using the same clock and baud parameterisation as the transmitter. Each received byte is presented with a single-cycle valid strobe for downstream logic, such as loading the LED counter from the host.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per bit period (10 MHz / 9600 baud); legal minimum 4.

Ports:
- clk, input, 1, system clock, rising-edge.
- reset, input, 1, asynchronous, active-high reset.
- rx, input, 1, serial line; asynchronous to clk; idles high.
- rx_data, output, 8, last correctly framed byte; held until the next good frame.
- rx_valid, output, 1, one-cycle pulse when rx_data updates.
- frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- One clock; reset is asynchronous and active-high; all state is reset by `reset`, with no synchronous clear.
- Reset values:
  - rx_data = 8'h00; rx_valid = 0; frame_err = 0; busy = 0.
  - FSM = IDLE; bit counter = 0; baud counter = 0.
  - Synchroniser flops = 1.
- Input sync: rx passes through 2 flops before use (rx_s); this adds 2 cycles of latency. No other filtering.
- Baud counter: width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer division).
- FSM states and transitions:
  - IDLE: baud counter = 0. rx_s == 0 → START.
  - START: count up to HALF-1 (the mid-start-bit point).
    - At that point, if rx_s == 0 → DATA, with baud counter and bit index cleared.
    - Otherwise → IDLE as a glitch: no output activity.
  - DATA: count up to CLKS_PER_BIT-1 (the mid-bit point).
    - Shift rx_s in LSB first. Bit index increments from 0 to 7.
    - After bit 7 → STOP.
  - STOP: count up to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: rx_data <= shift register; rx_valid = 1 for exactly one cycle; → IDLE.
    - If 0: frame_err = 1 for exactly one cycle; rx_data unchanged; → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1 → IDLE. This prevents a held break from re-triggering frames.
- busy is high in START, DATA, STOP and WAIT_HIGH. It goes low in the same cycle the FSM enters IDLE.
- Latency: the valid/err pulse occurs 2 + HALF + 9·CLKS_PER_BIT cycles (±1) after the rx falling edge.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit. A start bit arriving immediately after a 1-bit stop is therefore caught with no gap required.
- rx_valid and frame_err are never asserted in the same cycle.
- Baud tolerance: sampling at mid-bit must tolerate ±4% period mismatch over a 10-bit frame.
- Reset mid-frame:
  - All outputs return to reset values immediately, asynchronously.
  - The partial byte is discarded.
  - The next start bit after reset deassertion is received normally.
- There is no overrun handling. The consumer must capture rx_data on the rx_valid pulse; it is held stable only until the next good frame completes.

Test Plan:
(all with CLKS_PER_BIT=16)
1. Send 0xA5, 8N1 → a single rx_valid pulse 154±1 cycles after the falling edge; rx_data = 0xA5; frame_err stays 0; busy drops in the cycle valid is asserted.
2. Glitch: rx low for 4 cycles then high → no rx_valid, no frame_err; busy high briefly then 0; rx_data keeps its prior value.
3. Break: rx held low for 20 bit times → exactly one frame_err pulse, no rx_valid, busy held high until rx returns high. A following 0x3C frame is received correctly.
4. Back-to-back 0x00 then 0xFF, 1 stop bit, no idle gap → two rx_valid pulses exactly 160±1 cycles apart, carrying 0x00 then 0xFF.
5. Assert reset during data bit 3 → rx_data = 0x00, rx_valid = 0, busy = 0 immediately. After release, frame 0x5A → rx_valid with 0x5A.
6. Sender bit period 16.6 cycles (+4%), then 15.4 cycles (−4%), sending 0x96 each time → both frames received as 0x96 with no frame_err.
